// File: rtl/spi_image_pkg.sv
// Shared types and constants for the SPI image receiver.
package spi_image_pkg;

    // Frame-level receive FSM states
    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WAIT_EXEC,
        RUN,
        DONE
    } rx_state_t;

    // Host command bytes
    localparam logic [7:0] CMD_START = 8'h00;
    localparam logic [7:0] CMD_EXEC  = 8'hFF;

    // One pixel is a 4-bit intensity
    typedef logic [3:0] pixel_t;

    // Select the low (hi=0) or high (hi=1) nibble of a byte
    function automatic pixel_t nibble(input logic [7:0] b, input logic hi);
        return hi ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI slave byte engine: synchronizes SCK/SS/MOSI into clk, assembles
// LSB-first bytes, flags frames that end mid-byte and shifts a byte out
// on MISO while tx_load was high at the start of the frame.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ss,
    input  logic       mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic       rx_strobe,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_d, ss_d;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;
    logic [7:0]             tx_sr;
    logic                   tx_active;

    // Synchronizer chains; SS idles high so reset does not fake a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync[0]  <= sck;
            ss_sync[0]   <= ss;
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                ss_sync[i]   <= ss_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Previous synchronized levels for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_d <= 1'b0;
            ss_d  <= 1'b1;
        end else begin
            sck_d <= sck_s;
            ss_d  <= ss_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_rise  = ss_s & ~ss_d;
    assign ss_fall  = ~ss_s & ss_d;

    // Byte assembly: the eighth rise completes the byte and strobes it out
    // one clk later; SS rising abandons any partial byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            if (ss_rise) begin
                if (bit_cnt != 3'd0) begin
                    frame_err <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (sck_rise && !ss_s) begin
                if (bit_cnt == 3'd7) begin
                    rx_byte   <= {mosi_s, shift};
                    rx_strobe <= 1'b1;
                    bit_cnt   <= '0;
                end else begin
                    shift[bit_cnt] <= mosi_s;
                    bit_cnt        <= bit_cnt + 3'd1;
                end
            end
        end
    end

    // Transmit shifter: loaded on SS fall so bit 0 is ready before the
    // first rise, advanced on each SCK fall within the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr     <= '0;
            tx_active <= 1'b0;
        end else if (ss_fall) begin
            tx_sr     <= tx_byte;
            tx_active <= tx_load;
        end else if (ss_rise) begin
            tx_active <= 1'b0;
        end else if (sck_fall && !ss_s) begin
            tx_sr <= {1'b0, tx_sr[7:1]};
        end
    end

    assign miso = tx_active & tx_sr[0];

endmodule

// File: rtl/spi_image_receiver.sv
// SPI image receiver top: decodes host frames into an image of 4-bit
// pixels, buffers them in a small FIFO for the classifier and returns
// the classified digit on MISO. Optional macro SPI_ECHO_EN turns MISO
// into a loopback of the previous received byte outside result frames.
module spi_image_receiver #(
    parameter int NUM_PIXELS  = 144,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    output logic [3:0] pix_data,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       img_start,
    input  logic [3:0] result,
    input  logic       result_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun_err
);

    import spi_image_pkg::*;

    localparam int              IMG_BYTES = NUM_PIXELS / 2;
    localparam int              BC_W      = $clog2(IMG_BYTES);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(IMG_BYTES - 1);
    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_V   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  TWO_V     = (PTR_W+1)'(2);

    logic       rx_strobe;
    logic [7:0] rx_byte;
    logic       tx_load;
    logic [7:0] tx_byte;

    rx_state_t       state, state_next;
    logic [BC_W-1:0] byte_cnt, byte_cnt_next;
    logic            busy_next;
    logic            img_start_next;
    logic            push_req;
    logic            result_load;
    pixel_t          result_q;

    pixel_t          mem [FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]  occ_after, free_after;
    logic [PTR_W-1:0] wr_idx0, wr_idx1;
    logic            pop, push_ok;

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_byte_rx (
        .clk      (clk),
        .rst      (rst),
        .sck      (SCK),
        .ss       (SS),
        .mosi     (MOSI),
        .tx_load  (tx_load),
        .tx_byte  (tx_byte),
        .miso     (MISO),
        .rx_strobe(rx_strobe),
        .rx_byte  (rx_byte),
        .frame_err(frame_err)
    );

`ifdef SPI_ECHO_EN
    logic [7:0] echo_q;

    // Remember the last completed byte for loopback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_q <= 8'h00;
        end else if (rx_strobe) begin
            echo_q <= rx_byte;
        end
    end

    // Every frame transmits: the result in DONE, the echo otherwise
    always_comb begin
        tx_load = 1'b1;
        tx_byte = (state == DONE) ? {4'b0000, result_q} : echo_q;
    end
`else
    // Only a frame that starts in DONE transmits the result
    always_comb begin
        tx_load = (state == DONE);
        tx_byte = {4'b0000, result_q};
    end
`endif

    // Frame FSM: next state, byte counter, busy and command pulses
    always_comb begin
        state_next     = state;
        byte_cnt_next  = byte_cnt;
        busy_next      = busy;
        img_start_next = 1'b0;
        push_req       = 1'b0;
        result_load    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_strobe && rx_byte == CMD_START) begin
                    state_next    = RECV;
                    byte_cnt_next = '0;
                end
            end
            RECV: begin
                if (rx_strobe) begin
                    push_req  = 1'b1;
                    busy_next = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        state_next = WAIT_EXEC;
                    end else begin
                        byte_cnt_next = byte_cnt + BC_W'(1);
                    end
                end
            end
            WAIT_EXEC: begin
                if (rx_strobe) begin
                    if (rx_byte == CMD_EXEC) begin
                        img_start_next = 1'b1;
                        state_next     = RUN;
                    end else if (rx_byte == CMD_START) begin
                        state_next    = RECV;
                        byte_cnt_next = '0;
                    end
                end
            end
            RUN: begin
                if (result_valid) begin
                    result_load = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (rx_strobe) begin
                    byte_cnt_next = '0;
                    state_next    = (rx_byte == CMD_START) ? RECV : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            busy      <= 1'b0;
            img_start <= 1'b0;
            result_q  <= '0;
        end else begin
            state     <= state_next;
            byte_cnt  <= byte_cnt_next;
            busy      <= busy_next;
            img_start <= img_start_next;
            if (result_load) begin
                result_q <= result;
            end
        end
    end

    // Pixel stream: a pixel transfers on any clk where pix_valid and
    // pix_ready are both high; pix_data is stable while pix_valid waits.
    assign pix_valid = (wr_ptr != rd_ptr);
    assign pix_data  = mem[rd_ptr[PTR_W-1:0]];
    assign pop       = pix_valid & pix_ready;

    // Room check counts a same-cycle pop as already freed
    always_comb begin
        occ_after  = (wr_ptr - rd_ptr) - {{PTR_W{1'b0}}, pop};
        free_after = DEPTH_V - occ_after;
        push_ok    = push_req && (free_after >= TWO_V);
        wr_idx0    = wr_ptr[PTR_W-1:0];
        wr_idx1    = wr_ptr[PTR_W-1:0] + PTR_W'(1);
    end

    // Pixel storage, low nibble ahead of high nibble
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx0] <= nibble(rx_byte, 1'b0);
            mem[wr_idx1] <= nibble(rx_byte, 1'b1);
        end
    end

    // FIFO pointers and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overrun_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + TWO_V;
            end
            if (push_req && !push_ok) begin
                overrun_err <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_image_receiver.sv
// Directed-plus-random bench for spi_image_receiver: a host-side SPI
// driver, a pixel monitor and a reference stream of expected pixels.
module tb_spi_image_receiver;

    localparam int NUM_PIXELS = 144;
    localparam int IMG_BYTES  = NUM_PIXELS / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       SCK, SS, MOSI, MISO;
    logic [3:0] pix_data;
    logic       pix_valid;
    logic       pix_ready = 1'b0;
    logic       img_start;
    logic [3:0] result;
    logic       result_valid;
    logic       busy, frame_err, overrun_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rdy_mode = 1;
    int         start_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    always #5 clk = ~clk;

    spi_image_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .SCK         (SCK),
        .SS          (SS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .img_start   (img_start),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    // Downstream ready: held low, held high or random per cycle
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Record accepted pixels and img_start pulses
    always @(negedge clk) begin
        if (rst === 1'b0 && pix_valid === 1'b1 && pix_ready === 1'b1)
            obs_q.push_back(pix_data);
        if (img_start === 1'b1)
            start_cnt++;
    end

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clock nbits of b out LSB first, capturing MISO before each rise
    task automatic clock_bits(input logic [7:0] b, input int nbits, output logic [7:0] mb);
        int h;
        mb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            h = $urandom_range(5, 8);
            MOSI = b[i];
            wait_clk(h);
            mb[i] = MISO;
            SCK = 1'b1;
            wait_clk(h);
            SCK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits, output logic [7:0] mb);
        SS = 1'b0;
        wait_clk(2);
        clock_bits(b, nbits, mb);
        wait_clk(6);
        SS = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] d;
        send_frame(b, 8, d);
    endtask

    // Reference: an accepted image byte becomes low nibble then high nibble
    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b[3:0]);
        exp_q.push_back(b[7:4]);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] mb, b;
        int         s0;

        rst = 1'b1; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
        result = 4'd0; result_valid = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(3);
        check("rst_miso", MISO, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_img_start", img_start, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun_err", overrun_err, 0);

        // IDLE: MISO content and non-command bytes ignored
        send_byte(8'h5A);
        send_frame(8'($urandom_range(1, 255)), 8, mb);
`ifdef SPI_ECHO_EN
        check("idle_echo", mb, 8'h5A);
`else
        check("idle_miso_zero", mb, 8'h00);
`endif
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(1, 255)));
        check("idle_no_pixels", obs_q.size(), 0);
        check("idle_busy", busy, 0);

        // Image 1: 72 x 0x21 with pix_ready high
        rdy_mode = 1;
        send_byte(8'h00);
        check("busy_before_data", busy, 0);
        for (int i = 0; i < IMG_BYTES; i++) begin
            send_byte(8'h21);
            expect_byte(8'h21);
            if (i == 0) check("busy_first_byte", busy, 1);
        end
        send_byte(8'h37);
        wait_clk(10);
        compare_stream("img1_pix");
        check("no_start_before_exec", start_cnt, 0);
        send_byte(8'hFF);
        check("img_start_once", start_cnt, 1);
        check("busy_in_run", busy, 1);

        // RUN: SPI ignored; result returned in the next frame
        send_byte(8'h00);
        check("run_no_pixels", obs_q.size(), 0);
        result = 4'd7;
        result_valid = 1'b1;
        wait_clk(1);
        result_valid = 1'b0;
        wait_clk(2);
        check("busy_after_result", busy, 0);
        send_frame(8'h55, 8, mb);
        check("result_on_miso", mb, 8'h07);
        send_frame(8'h33, 8, mb);
`ifdef SPI_ECHO_EN
        check("after_done_echo", mb, 8'h55);
`else
        check("after_done_miso_zero", mb, 8'h00);
`endif
        check("after_done_no_pixels", obs_q.size(), 0);

        // Image 2: random data with random pix_ready
        rdy_mode = 2;
        send_byte(8'h00);
        for (int i = 0; i < IMG_BYTES; i++) begin
            b = 8'($urandom);
            send_byte(b);
            expect_byte(b);
        end
        rdy_mode = 1;
        wait_clk(20);
        compare_stream("img2_pix");
        check("overrun_clear", overrun_err, 0);

        // WAIT_EXEC restart keeps busy and re-enters RECV
        send_byte(8'h00);
        check("restart_busy", busy, 1);
        b = 8'($urandom);
        send_byte(b);
        expect_byte(b);
        wait_clk(10);
        compare_stream("restart_pix");

        // Reset in the middle of a byte
        SS = 1'b0;
        wait_clk(2);
        clock_bits(8'hA5, 4, mb);
        rst = 1'b1;
        wait_clk(2);
        check("midrst_busy", busy, 0);
        check("midrst_pix_valid", pix_valid, 0);
        check("midrst_miso", MISO, 0);
        check("midrst_img_start", img_start, 0);
        SS = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        send_byte(8'h43);
        wait_clk(10);
        check("post_rst_no_pixels", obs_q.size(), 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_frame_err", frame_err, 0);

        // Partial frame, then overrun with pix_ready low
        send_frame(8'h00, 5, mb);
        check("frame_err_set", frame_err, 1);
        check("partial_no_pixels", obs_q.size(), 0);
        rdy_mode = 0;
        wait_clk(2);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h21);
            expect_byte(8'h21);
        end
        check("full_no_overrun", overrun_err, 0);
        check("full_pix_valid", pix_valid, 1);
        send_byte(8'h21);
        check("overrun_set", overrun_err, 1);
        rdy_mode = 1;
        wait_clk(20);
        compare_stream("drain_pix");
        for (int i = 5; i < IMG_BYTES; i++) begin
            b = 8'($urandom);
            send_byte(b);
            expect_byte(b);
        end
        wait_clk(10);
        compare_stream("tail_pix");
        s0 = start_cnt;
        send_byte(8'hFF);
        check("exec_after_drop", start_cnt - s0, 1);
        check("frame_err_sticky", frame_err, 1);
        check("overrun_sticky", overrun_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
